sram_controller: RTL
====================

// Module: sram_controller
// PURPOSE
//   Sequences data-memory accesses from the MEM stage onto an external 16-bit asynchronous SRAM.
//   Each 32-bit word is moved as two 16-bit halves, with programmable wait states per half.
//   Drives ready low while an access is in flight. Top-level ORs ~ready into the pipeline freeze,
//   stalling IF..MEM until the access completes.
// PARAMETERS
//   WAIT_CYCLES  5     cycles per 16-bit half access (legal range 1..15)
//   ADDR_BASE    1024  byte address that maps to SRAM word 0
// PORTS
//   clk          in   1   clock, rising edge
//   rst          in   1   synchronous, active-high reset
//   wr_en        in   1   MEM-stage store request (level, held until ready)
//   rd_en        in   1   MEM-stage load request (level, held until ready)
//   address      in   32  byte address (ALU result)
//   write_data   in   32  store data (Val_Rm)
//   read_data    out  32  load data, valid in the cycle ready rises for a load
//   ready        out  1   1 = no access pending or access completing this cycle
//   sram_addr    out  18  SRAM half-word address
//   sram_dq_o    out  16  data driven to SRAM
//   sram_dq_i    in   16  data returned from SRAM
//   sram_dq_oe   out  1   1 = controller drives the DQ bus
//   sram_we_n    out  1   SRAM write strobe, active low
// BEHAVIOUR
//   - Address mapping:
//     - word = (address - ADDR_BASE) >> 2, using 32-bit modular subtraction with no range check.
//     - sram_addr = {word[16:0], half}, where half = 0 in ACC_LO and 1 in ACC_HI.
//   - States: IDLE, ACC_LO, ACC_HI, DONE.
//   - 4-bit wait counter cnt:
//     - cleared on entry to ACC_LO and ACC_HI.
//     - increments each cycle; the state advances when cnt == WAIT_CYCLES-1.
//   - Transitions:
//     - IDLE -> ACC_LO when (rd_en | wr_en); the op type is latched.
//     - ACC_LO -> ACC_HI and ACC_HI -> DONE after WAIT_CYCLES cycles each.
//     - DONE -> IDLE unconditionally. Requests seen in DONE are never restarted.
//   - ready (combinational) = (IDLE & ~rd_en & ~wr_en) | DONE.
//   - Latency:
//     - request first visible in IDLE at cycle 0 -> ready=0 in cycles 0..2*WAIT_CYCLES.
//     - ready=1 in cycle 2*WAIT_CYCLES+1 (DONE).
//     - a new request in the following cycle starts immediately.
//   - Write:
//     - sram_dq_oe=1 in ACC_LO/ACC_HI.
//     - sram_dq_o = write_data[15:0] in ACC_LO, write_data[31:16] in ACC_HI.
//     - sram_we_n=0 in all but the last wait cycle of each half. The last cycle has we_n=1 for data hold.
//     - WAIT_CYCLES=1: we_n is low for the single cycle.
//   - Read:
//     - sram_dq_oe=0 and sram_we_n=1 throughout.
//     - sram_dq_i is sampled into read_data[15:0] on the last ACC_LO cycle and into read_data[31:16] on the last ACC_HI cycle.
//   - read_data holds its value until the next load overwrites it. Stores never change it.
//   - rd_en & wr_en both high: treated as a write.
//   - Address/data are latched at IDLE->ACC_LO, so later input changes are ignored.
//   - Reset values, including rst mid-access (abort, no completion):
//     - state IDLE, cnt 0, read_data 0.
//     - sram_we_n 1, sram_dq_oe 0, sram_addr 0, sram_dq_o 0.
// CONFIGURATION
//   SRAM_CTRL_STATS_EN defined:
//     - extra outputs rd_count[15:0] and wr_count[15:0].
//     - each increments by 1 in the DONE cycle of a load/store; wraps at 16'hFFFF -> 0; reset to 0.
//   Not defined: those ports and counters do not exist; all other behaviour is identical.
// TESTING
//   1. rst=1 for 2 cycles -> ready=1, we_n=1, dq_oe=0, read_data=0; rst=0 with no request -> ready stays 1.
//   2. wr_en, address=1024, write_data=32'hDEADBEEF (WAIT=5):
//      - addr 0 gets 16'hBEEF; addr 1 gets 16'hDEAD.
//      - ready=0 for 11 cycles, 1 on cycle 12.
//   3. rd_en, address=1024, SRAM model from test 2 -> read_data=32'hDEADBEEF when ready rises; no we_n pulse.
//   4. Back-to-back: store to 1028 then load from 1028 -> second access starts the cycle after DONE; load returns the stored word.
//   5. rd_en & wr_en together, address=1032, data=32'h12345678 -> write performed; read_data unchanged.
//   6. rst asserted on cycle 3 of ACC_LO:
//      - next cycle IDLE, we_n=1, ready=1.
//      - with STATS_EN, the counters are 0 and the aborted op is not counted.

Source files
------------

// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
//
// Moves 32-bit MEM-stage loads and stores to and from an external 16-bit
// asynchronous SRAM. Each word is transferred as two 16-bit halves: the low
// half first, then the high half. Each half lasts WAIT_CYCLES clock cycles.
// While an access is in flight, ready is low. The top level uses ~ready to
// freeze the pipeline.
//
// Optional feature macro: SRAM_CTRL_STATS_EN
//   When defined, the rd_count/wr_count completion counters and their ports
//   are added. When undefined, they do not exist.
//
// Parameters
//   WAIT_CYCLES  cycles per 16-bit half access (1..15)
//   ADDR_BASE    byte address that maps to SRAM word 0
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset (aborts any access)
//   wr_en       in   store request (level, held until ready)
//   rd_en       in   load request (level, held until ready)
//   address     in   [31:0] byte address
//   write_data  in   [31:0] store data
//   read_data   out  [31:0] load data, valid in the cycle ready rises
//   ready       out  1 = nothing pending, or access completing this cycle
//   sram_addr   out  [17:0] SRAM half-word address
//   sram_dq_o   out  [15:0] data driven to the SRAM
//   sram_dq_i   in   [15:0] data returned by the SRAM
//   sram_dq_oe  out  1 = controller drives the DQ bus
//   sram_we_n   out  SRAM write strobe, active low
//   rd_count    out  [15:0] completed loads   (SRAM_CTRL_STATS_EN only)
//   wr_count    out  [15:0] completed stores  (SRAM_CTRL_STATS_EN only)
//   state_dbg   out  [1:0] FSM state: 0 IDLE, 1 ACC_LO, 2 ACC_HI, 3 DONE
//
// Request/ready handshake: the requester raises rd_en or wr_en and keeps it
// high. The request is accepted in the first IDLE cycle where it is seen;
// address, write_data and the op type are captured on that edge. The access
// completes in the cycle where ready is 1 while the request is still high.
// The requester must drop or change the request on the following edge. Any
// request still high in DONE is not restarted; one still high in the next
// IDLE cycle starts a new access.
// ---------------------------------------------------------------------------
module sram_controller #(
    parameter int WAIT_CYCLES = 5,
    parameter int ADDR_BASE   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_o,
    input  logic [15:0] sram_dq_i,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
`ifdef SRAM_CTRL_STATS_EN
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
`endif
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0]  LAST_CNT = 4'(WAIT_CYCLES - 1);
    localparam logic [31:0] BASE     = 32'(ADDR_BASE);
    // With a single cycle per half there is no spare hold cycle, so the
    // strobe stays low for that one cycle.
    localparam bit          SINGLE   = (WAIT_CYCLES == 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        op_write;
    logic [16:0] word_q;
    logic [31:0] data_q;

    state_t      nxt_state;
    logic [3:0]  nxt_cnt;
    logic        nxt_write;
    logic [16:0] nxt_word;
    logic [31:0] nxt_data;
    logic        nxt_in_acc;
    logic        nxt_half;
    logic        nxt_we_low;

    // The SRAM pins are registered. They are computed from the next state so
    // they line up with the state they belong to, without glitching.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_write = op_write;
        nxt_word  = word_q;
        nxt_data  = data_q;
        case (state)
            IDLE: begin
                nxt_cnt = 4'd0;
                if (rd_en || wr_en) begin
                    nxt_state = ACC_LO;
                    // When both requests are high, the access is a store.
                    nxt_write = wr_en;
                    // Modular subtraction: addresses below the base wrap.
                    nxt_word  = 17'((address - BASE) >> 2);
                    nxt_data  = write_data;
                end
            end
            ACC_LO: begin
                if (cnt == LAST_CNT) begin
                    nxt_state = ACC_HI;
                    nxt_cnt   = 4'd0;
                end else begin
                    nxt_cnt = cnt + 4'd1;
                end
            end
            ACC_HI: begin
                if (cnt == LAST_CNT) begin
                    nxt_state = DONE;
                    nxt_cnt   = 4'd0;
                end else begin
                    nxt_cnt = cnt + 4'd1;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = 4'd0;
            end
        endcase
        nxt_in_acc = (nxt_state == ACC_LO) || (nxt_state == ACC_HI);
        nxt_half   = (nxt_state == ACC_HI);
        // The strobe is released in the last wait cycle so data and address
        // stay stable after the write edge.
        nxt_we_low = nxt_write && nxt_in_acc && (SINGLE || (nxt_cnt != LAST_CNT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            op_write   <= 1'b0;
            word_q     <= 17'd0;
            data_q     <= 32'd0;
            read_data  <= 32'd0;
            sram_addr  <= 18'd0;
            sram_dq_o  <= 16'd0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            op_write   <= nxt_write;
            word_q     <= nxt_word;
            data_q     <= nxt_data;
            sram_we_n  <= ~nxt_we_low;
            sram_dq_oe <= nxt_write && nxt_in_acc;
            sram_dq_o  <= (nxt_write && nxt_in_acc)
                          ? (nxt_half ? nxt_data[31:16] : nxt_data[15:0])
                          : 16'd0;
            if (nxt_in_acc) begin
                sram_addr <= {nxt_word, nxt_half};
            end
            // Load data is sampled at the end of each half's last wait
            // cycle, after the SRAM access time has elapsed.
            if (!op_write && (cnt == LAST_CNT)) begin
                if (state == ACC_LO) begin
                    read_data[15:0] <= sram_dq_i;
                end
                if (state == ACC_HI) begin
                    read_data[31:16] <= sram_dq_i;
                end
            end
        end
    end

`ifdef SRAM_CTRL_STATS_EN
    // A completed access is counted once, in its DONE cycle. Accesses aborted
    // by reset never reach DONE, so they are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else if (state == DONE) begin
            if (op_write) begin
                wr_count <= wr_count + 16'd1;
            end else begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

    always_comb begin
        ready = ((state == IDLE) && !rd_en && !wr_en) || (state == DONE);
    end

    assign state_dbg = state;

endmodule
